// File: rtl/operand_fetch.sv
// Operand fetch stage: 32-entry register file, operand select and a valid/ready
// output register feeding the ALU. Define WB_BYPASS_EN for write-through forwarding.
module operand_fetch #(
  parameter int NREGS = 32,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [15:0]      imm,
  input  logic             ALUSrc,
  input  logic [2:0]       ALUOpIn,
  input  logic             RegWrite,
  input  logic [AW-1:0]    WriteReg,
  input  logic [WIDTH-1:0] WriteData,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [2:0]       ALUOp
);

  logic [WIDTH-1:0] regs [NREGS];
  logic             wb_en;
  logic             capture;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] op2;

  assign wb_en    = RegWrite && (WriteReg != '0);
  assign in_ready = !out_valid || out_ready;
  assign capture  = in_valid && in_ready;
  assign imm_ext  = {{(WIDTH-16){imm[15]}}, imm};

  // NOTE: the register file is cleared by reset because the stage must come up
  // with every architectural register reading zero; this costs a reset on each flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en) begin
      regs[WriteReg] <= WriteData;
    end
  end

  // NOTE: every variable assigned here gets a value before any condition, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rd1 = (rs == '0) ? '0 : regs[rs];
    rd2 = (rt == '0) ? '0 : regs[rt];
`ifdef WB_BYPASS_EN
    if (wb_en && (WriteReg == rs)) rd1 = WriteData;
    if (wb_en && (WriteReg == rt)) rd2 = WriteData;
`endif
    op2 = ALUSrc ? imm_ext : rd2;
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      data1     <= '0;
      data2     <= '0;
      ALUOp     <= 3'b000;
    end else if (capture) begin
      out_valid <= 1'b1;
      data1     <= rd1;
      data2     <= op2;
      ALUOp     <= ALUOpIn;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed vector table, hand-written
// reset/bypass sequences and a randomized run against a register-array model.
module tb_operand_fetch;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic        ALUSrc;
  logic [2:0]  ALUOpIn;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] data1;
  logic [31:0] data2;
  logic [2:0]  ALUOp;

  int checks   = 0;
  int failures = 0;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  operand_fetch dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .imm(imm), .ALUSrc(ALUSrc), .ALUOpIn(ALUOpIn),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .out_valid(out_valid), .out_ready(out_ready),
    .data1(data1), .data2(data2), .ALUOp(ALUOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        src;
    logic [2:0]  op;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ordy;
    logic        x_irdy;
    logic        x_ov;
    logic [31:0] x_d1;
    logic [31:0] x_d2;
    logic [2:0]  x_op;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic apply(input logic iv, input logic [4:0] rs_i, input logic [4:0] rt_i,
                       input logic [15:0] imm_i, input logic src, input logic [2:0] op,
                       input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic ordy);
    in_valid  = iv;
    rs        = rs_i;
    rt        = rt_i;
    imm       = imm_i;
    ALUSrc    = src;
    ALUOpIn   = op;
    RegWrite  = we;
    WriteReg  = wr;
    WriteData = wd;
    out_ready = ordy;
  endtask

  task automatic idle();
    apply(1'b0, 5'd0, 5'd0, 16'h0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    tick();
    #3;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Model: architectural registers plus the single operation held for the ALU.
  logic [31:0] mregs [32];
  logic        m_valid;
  logic [31:0] m_d1;
  logic [31:0] m_d2;
  logic [2:0]  m_op;

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (BYP && RegWrite && WriteReg == idx) return WriteData;
    return mregs[idx];
  endfunction

  initial begin
    vec_t v;
    reset = 1'b0;
    idle();
    do_reset();

    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_data1", data1, 32'h0);
    check("reset_data2", data2, 32'h0);
    check("reset_aluop", {29'h0, ALUOp}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);

    //           iv  rs  rt   imm     src op     we  wr  wd            ordy irdy ov  d1        d2            op
    vecs[0]  = '{1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 3'b000, 1'b1, 5'd5, 32'h7,        1'b1, 1'b1, 1'b0, 32'h0,  32'h0,        3'b000};
    vecs[1]  = '{1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 3'b000, 1'b1, 5'd6, 32'h3,        1'b1, 1'b1, 1'b0, 32'h0,  32'h0,        3'b000};
    vecs[2]  = '{1'b1, 5'd5, 5'd6, 16'h0000, 1'b0, 3'b110, 1'b0, 5'd0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h7,  32'h3,        3'b110};
    vecs[3]  = '{1'b1, 5'd5, 5'd0, 16'hFFFE, 1'b1, 3'b010, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h7,  32'hFFFF_FFFE, 3'b010};
    vecs[4]  = '{1'b1, 5'd5, 5'd0, 16'h7FFF, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h7,  32'h0000_7FFF, 3'b000};
    vecs[5]  = '{1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 3'b000, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 32'h7,  32'h0000_7FFF, 3'b000};
    vecs[6]  = '{1'b1, 5'd0, 5'd5, 16'h0000, 1'b0, 3'b111, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,  32'h7,        3'b111};
    vecs[7]  = '{1'b1, 5'd5, 5'd6, 16'h0000, 1'b0, 3'b001, 1'b1, 5'd5, 32'h55,       1'b0, 1'b0, 1'b1, 32'h0,  32'h7,        3'b111};
    vecs[8]  = '{1'b1, 5'd5, 5'd6, 16'h0000, 1'b0, 3'b001, 1'b1, 5'd6, 32'h66,       1'b0, 1'b0, 1'b1, 32'h0,  32'h7,        3'b111};
    vecs[9]  = '{1'b1, 5'd5, 5'd6, 16'h0000, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h0,  32'h7,        3'b111};
    vecs[10] = '{1'b1, 5'd5, 5'd6, 16'h0000, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h55, 32'h66,       3'b001};
    vecs[11] = '{1'b0, 5'd0, 5'd0, 16'h0000, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 1'b0, 32'h55, 32'h66,       3'b001};

    for (int i = 0; i < 12; i++) begin
      v = vecs[i];
      apply(v.iv, v.rs, v.rt, v.imm, v.src, v.op, v.we, v.wr, v.wd, v.ordy);
      #1;
      check($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, v.x_irdy});
      tick();
      check($sformatf("vec%0d_out_valid", i), {31'h0, out_valid}, {31'h0, v.x_ov});
      check($sformatf("vec%0d_data1", i), data1, v.x_d1);
      check($sformatf("vec%0d_data2", i), data2, v.x_d2);
      check($sformatf("vec%0d_aluop", i), {29'h0, ALUOp}, {29'h0, v.x_op});
    end

    // Asynchronous reset while an operation is held.
    apply(1'b1, 5'd5, 5'd6, 16'h0, 1'b0, 3'b010, 1'b0, 5'd0, 32'h0, 1'b0);
    tick();
    check("pre_reset_valid", {31'h0, out_valid}, 32'h1);
    idle();
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_valid", {31'h0, out_valid}, 32'h0);
    check("async_reset_data1", data1, 32'h0);
    check("async_reset_data2", data2, 32'h0);
    check("async_reset_aluop", {29'h0, ALUOp}, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    apply(1'b1, 5'd5, 5'd5, 16'h0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    check("post_reset_r5_data1", data1, 32'h0);
    check("post_reset_r5_data2", data2, 32'h0);

    // Same-cycle writeback and capture.
    apply(1'b1, 5'd7, 5'd0, 16'h0, 1'b0, 3'b010, 1'b1, 5'd7, 32'h1234, 1'b1);
    tick();
    check("same_cycle_rs_data1", data1, BYP ? 32'h1234 : 32'h0);
    apply(1'b1, 5'd7, 5'd0, 16'h0, 1'b0, 3'b010, 1'b0, 5'd0, 32'h0, 1'b1);
    tick();
    check("later_read_r7", data1, 32'h1234);
    apply(1'b1, 5'd0, 5'd9, 16'h0, 1'b0, 3'b000, 1'b1, 5'd9, 32'hABCD, 1'b1);
    tick();
    check("same_cycle_rt_data2", data2, BYP ? 32'hABCD : 32'h0);
    apply(1'b1, 5'd0, 5'd7, 16'h0, 1'b0, 3'b000, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1);
    tick();
    check("r0_never_bypassed", data1, 32'h0);
    check("r0_rt_read", data2, 32'h1234);

    // Randomized run against the model.
    do_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    m_valid = 1'b0;
    m_d1 = 32'h0;
    m_d2 = 32'h0;
    m_op = 3'b000;
    for (int n = 0; n < 500; n++) begin
      logic        exp_rdy;
      logic [31:0] sext;
      apply(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
            5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 9) < 6));
      #1;
      exp_rdy = !m_valid || out_ready;
      check("rand_in_ready", {31'h0, in_ready}, {31'h0, exp_rdy});
      if (in_valid && exp_rdy) begin
        sext = {{16{imm[15]}}, imm};
        m_d1 = model_read(rs);
        m_d2 = ALUSrc ? sext : model_read(rt);
        m_op = ALUOpIn;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (RegWrite && WriteReg != 5'd0) mregs[WriteReg] = WriteData;
      tick();
      check("rand_out_valid", {31'h0, out_valid}, {31'h0, m_valid});
      check("rand_data1", data1, m_d1);
      check("rand_data2", data2, m_d2);
      check("rand_aluop", {29'h0, ALUOp}, {29'h0, m_op});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
